// File: rtl/gpu_apb_master_if.sv
// Bundles the host command handshake and the APB write bus of gpu_apb_master.
// Handshake: a command transfers on a rising edge when cmd_valid_i && cmd_ready_o; the producer holds addr/data while valid && !ready.
interface gpu_apb_master_if;
  logic        cmd_valid_i;
  logic [31:0] cmd_addr_i;
  logic [31:0] cmd_data_i;
  logic        cmd_ready_o;
  logic [31:0] pAddr_o;
  logic [31:0] pDataWrite_o;
  logic        pSel_o;
  logic        pEnable_o;
  logic        pWrite_o;

  modport master (
    input  cmd_valid_i, cmd_addr_i, cmd_data_i,
    output cmd_ready_o, pAddr_o, pDataWrite_o, pSel_o, pEnable_o, pWrite_o
  );

  modport slave (
    output cmd_valid_i, cmd_addr_i, cmd_data_i,
    input  cmd_ready_o, pAddr_o, pDataWrite_o, pSel_o, pEnable_o, pWrite_o
  );
endinterface

// File: rtl/gpu_apb_master.sv
// APB write initiator: buffers host commands in a small FIFO and issues each
// as a zero-wait-state APB write (SETUP then ACCESS), back-to-back when possible.
module gpu_apb_master #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_BITS   = 16
) (
  input  logic                          clk,
  input  logic                          n_rst,
  gpu_apb_master_if.master              bus_if,
  output logic                          idle_o,
  output logic                          xfer_done_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
  output logic [CNT_BITS-1:0]           txn_count_o,
  output logic [1:0]                    state_o
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [31:0]         addr_mem [FIFO_DEPTH];
  logic [31:0]         data_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                full, empty, push, pop;

  logic [31:0]         paddr_q, paddr_d;
  logic [31:0]         pdata_q, pdata_d;
  logic                psel_q, psel_d;
  logic                penable_q, penable_d;
  logic [CNT_BITS-1:0] txn_count_q, txn_count_d;

  // Full/empty come from the occupancy count so wrapped pointers never alias.
  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign push  = bus_if.cmd_valid_i && !full;
  assign pop   = !empty && ((state_q == IDLE) || (state_q == ACCESS));

  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk) begin
    if (!n_rst && push) begin
      addr_mem[wr_ptr_q] <= bus_if.cmd_addr_i;
      data_mem[wr_ptr_q] <= bus_if.cmd_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (n_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!empty) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  state_d = empty ? IDLE : SETUP;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered APB outputs; address/data only move on a pop.
  always_comb begin
    paddr_d     = paddr_q;
    pdata_d     = pdata_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    txn_count_d = txn_count_q;
    case (state_q)
      IDLE: begin
        psel_d    = !empty;
        penable_d = 1'b0;
      end
      SETUP: begin
        psel_d    = 1'b1;
        penable_d = 1'b1;
      end
      ACCESS: begin
        psel_d      = !empty;
        penable_d   = 1'b0;
        txn_count_d = txn_count_q + 1'b1;
      end
      default: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase
    if (pop) begin
      paddr_d = addr_mem[rd_ptr_q];
      pdata_d = data_mem[rd_ptr_q];
    end
  end

  always_ff @(posedge clk) begin
    if (n_rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      paddr_q     <= '0;
      pdata_q     <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      txn_count_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      paddr_q     <= paddr_d;
      pdata_q     <= pdata_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      txn_count_q <= txn_count_d;
    end
  end

  assign bus_if.cmd_ready_o  = !full;
  assign bus_if.pAddr_o      = paddr_q;
  assign bus_if.pDataWrite_o = pdata_q;
  assign bus_if.pSel_o       = psel_q;
  assign bus_if.pEnable_o    = penable_q;
  assign bus_if.pWrite_o     = 1'b1;
  assign idle_o              = (state_q == IDLE) && empty;
  assign xfer_done_o         = (state_q == ACCESS);
  assign fifo_count_o        = count_q;
  assign txn_count_o         = txn_count_q;
  assign state_o             = state_q;
endmodule

// File: tb/tb_gpu_apb_master.sv
// Bench for gpu_apb_master: directed scenarios plus random traffic, checked every
// cycle against a queue-based transaction model of the command buffer and APB phases.
module tb_gpu_apb_master;
  localparam int DEPTH = 4;
  localparam int CW    = 16;

  logic          clk = 1'b0;
  logic          n_rst;
  logic          idle, xfer_done;
  logic [2:0]    fifo_count;
  logic [CW-1:0] txn_count;
  logic [1:0]    state;

  gpu_apb_master_if bus_if ();

  gpu_apb_master #(.FIFO_DEPTH(DEPTH), .CNT_BITS(CW)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .bus_if       (bus_if),
    .idle_o       (idle),
    .xfer_done_o  (xfer_done),
    .fifo_count_o (fifo_count),
    .txn_count_o  (txn_count),
    .state_o      (state)
  );

  always #5 clk = ~clk;

  // Model: exp_q holds buffered commands, m_phase is 0 none / 1 setup / 2 access.
  logic [63:0]   exp_q[$];
  logic [63:0]   acc_q[$];
  int            m_phase;
  logic [31:0]   m_addr, m_data;
  logic [CW-1:0] m_txn;
  int            n_tests = 0;
  int            n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_tests++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic drive(input bit v, input logic [31:0] a, input logic [31:0] d);
    bus_if.cmd_valid_i = v;
    bus_if.cmd_addr_i  = a;
    bus_if.cmd_data_i  = d;
  endtask

  task automatic step(output bit accepted);
    bit          v, rst, ready, had;
    logic [63:0] cmd, head;
    v        = bus_if.cmd_valid_i;
    rst      = n_rst;
    cmd      = {bus_if.cmd_addr_i, bus_if.cmd_data_i};
    ready    = exp_q.size() < DEPTH;
    accepted = 1'b0;
    @(posedge clk);
    if (rst) begin
      exp_q.delete();
      acc_q.delete();
      m_phase = 0;
      m_addr  = '0;
      m_data  = '0;
      m_txn   = '0;
    end else begin
      had      = exp_q.size() > 0;
      accepted = v && ready;
      if (m_phase == 2) m_txn = m_txn + 1'b1;
      if (m_phase == 1) begin
        m_phase = 2;
      end else if (had) begin
        head    = exp_q.pop_front();
        m_addr  = head[63:32];
        m_data  = head[31:0];
        m_phase = 1;
      end else begin
        m_phase = 0;
      end
      if (accepted) begin
        exp_q.push_back(cmd);
        acc_q.push_back(cmd);
      end
    end
    #1;
    check("psel",       bus_if.pSel_o,       m_phase != 0);
    check("penable",    bus_if.pEnable_o,    m_phase == 2);
    check("xfer_done",  xfer_done,           m_phase == 2);
    check("paddr",      bus_if.pAddr_o,      m_addr);
    check("pdata",      bus_if.pDataWrite_o, m_data);
    check("pwrite",     bus_if.pWrite_o,     1'b1);
    check("fifo_count", fifo_count,          exp_q.size());
    check("cmd_ready",  bus_if.cmd_ready_o,  exp_q.size() < DEPTH);
    check("idle",       idle,                (m_phase == 0) && (exp_q.size() == 0));
    check("txn_count",  txn_count,           m_txn);
    // Order scoreboard: every ACCESS must carry the oldest accepted command.
    if (bus_if.pSel_o && bus_if.pEnable_o) begin
      if (acc_q.size() == 0) begin
        check("acc_extra", 1'b1, 1'b0);
      end else begin
        head = acc_q.pop_front();
        check("acc_order", {bus_if.pAddr_o, bus_if.pDataWrite_o}, head);
      end
    end
  endtask

  task automatic idle_cycles(input int n);
    bit acc;
    drive(1'b0, '0, '0);
    for (int i = 0; i < n; i++) step(acc);
  endtask

  initial begin
    bit          acc, saw_full;
    int          i, guard;
    bit          cur_v;
    logic [31:0] cur_a, cur_d;

    m_phase = 0; m_addr = '0; m_data = '0; m_txn = '0;

    // 1: reset with valid held high
    n_rst = 1'b1;
    drive(1'b1, 32'hDEAD_0000, 32'hBEEF_0000);
    step(acc);
    step(acc);
    check("t1_no_push", fifo_count, 0);
    check("t1_ready",   bus_if.cmd_ready_o, 1'b1);
    check("t1_idle",    idle, 1'b1);
    n_rst = 1'b0;
    drive(1'b0, '0, '0);
    step(acc);

    // 2: single command
    drive(1'b1, 32'h0000_0004, 32'h1234_5678);
    step(acc);
    check("t2_accept", acc, 1'b1);
    idle_cycles(5);
    check("t2_txn",  txn_count, 1);
    check("t2_idle", idle, 1'b1);

    // 3: four consecutive pushes
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 32'h0000_0010 + 32'(k * 4), 32'hA0 + 32'(k));
      step(acc);
    end
    idle_cycles(10);
    check("t3_txn", txn_count, 5);

    // 4: eight commands with valid held; producer holds while not ready
    i = 0; guard = 0; saw_full = 1'b0;
    while (i < 8 && guard < 100) begin
      drive(1'b1, 32'h0000_0100 + 32'(i * 4), 32'hB0 + 32'(i));
      step(acc);
      if (!bus_if.cmd_ready_o && fifo_count == 3'd4) saw_full = 1'b1;
      if (acc) i++;
      guard++;
    end
    check("t4_all_accepted", i, 8);
    check("t4_full_seen", saw_full, 1'b1);
    idle_cycles(20);
    check("t4_txn", txn_count, 13);

    // 5: reset during ACCESS of the 2nd of 3 queued commands
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 32'h0000_0200 + 32'(k * 4), 32'hC0 + 32'(k));
      step(acc);
    end
    drive(1'b0, '0, '0);
    guard = 0;
    while (!(m_phase == 2 && m_txn == 14) && guard < 20) begin
      step(acc);
      guard++;
    end
    check("t5_reached_access", m_phase == 2 && m_txn == 14, 1'b1);
    check("t5_second_cmd", bus_if.pDataWrite_o, 32'hC1);
    n_rst = 1'b1;
    step(acc);
    n_rst = 1'b0;
    check("t5_psel",  bus_if.pSel_o, 1'b0);
    check("t5_count", fifo_count, 0);
    check("t5_txn",   txn_count, 0);
    idle_cycles(6);

    // 6: counter wrap, preloaded by force
    force dut.txn_count_q = 16'hFFFE;
    m_txn = 16'hFFFE;
    step(acc);
    release dut.txn_count_q;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 32'h0000_0300 + 32'(k * 4), 32'hD0 + 32'(k));
      step(acc);
    end
    idle_cycles(8);
    check("t6_wrap", txn_count, 16'h0001);

    // Random traffic with one mid-run reset
    cur_v = 1'b0; cur_a = '0; cur_d = '0; acc = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!cur_v || acc) begin
        cur_v = ($urandom_range(0, 3) != 0);
        cur_a = $urandom;
        cur_d = $urandom;
      end
      n_rst = (c == 250);
      drive(cur_v, cur_a, cur_d);
      step(acc);
    end
    n_rst = 1'b0;
    idle_cycles(12);
    check("final_drained", acc_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
